// File: rtl/ssm_funnel_shifter_p_pkg.sv
// Shared defaults, width helper and error-cause encoding for the substream funnel shifter.
package ssm_pkg;

  localparam int IN_W_DEF  = 128;
  localparam int WIN_W_DEF = 128;
  localparam int BUF_W_DEF = 256;
  localparam int ALIGN_DEF = 8;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_ALIGN     = 2'd2,
    ERR_CONFLICT  = 2'd3
  } err_cause_e;

  function automatic int calc_cw(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/ssm_funnel_shifter_p_barrel_shl.sv
// Log-stage left barrel shifter; shift amounts of W or more yield zero.
module ssm_barrel_shl
  import ssm_pkg::*;
#(
  parameter int W  = BUF_W_DEF,
  parameter int SW = calc_cw(BUF_W_DEF)
) (
  input  logic [W-1:0]  i_data,
  input  logic [SW-1:0] i_shamt,
  output logic [W-1:0]  o_data
);

  logic [W-1:0] w_stage [0:SW];

  assign w_stage[0] = i_data;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int SH = 2 ** k;
    if (SH >= W) begin : g_zero
      assign w_stage[k+1] = i_shamt[k] ? '0 : w_stage[k];
    end else begin : g_shift
      assign w_stage[k+1] = i_shamt[k] ? (w_stage[k] << SH) : w_stage[k];
    end
  end

  assign o_data = w_stage[SW];

endmodule

// File: rtl/ssm_funnel_shifter_p.sv
// Substream funnel shifter: MSB-aligned bit buffer with peek window, variable retire,
// byte alignment, flush and end-of-stream drain.
module ssm_funnel_shifter_p
  import ssm_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int BUF_W = BUF_W_DEF,
  parameter int ALIGN = ALIGN_DEF,
  parameter int CW    = calc_cw(BUF_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eos,
  output logic [WIN_W-1:0] win_data,
  output logic             win_valid,
  output logic [CW-1:0]    fullness,
  input  logic             consume_en,
  input  logic [CW-1:0]    consume_bits,
  input  logic             align_en,
  input  logic             flush,
  output logic [31:0]      total_consumed,
  output logic             err,
  input  logic             err_clr
);

  logic [BUF_W-1:0] r_buf;
  logic [CW-1:0]    r_full;
  logic [31:0]      r_total;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic [CW-1:0]    w_tot_mod;
  logic [CW-1:0]    w_align_d;
  logic [CW-1:0]    w_ret;
  err_cause_e       w_cause;
  logic             w_set_err;
  logic [CW-1:0]    w_place_sh;
  logic [BUF_W-1:0] w_buf_shl;
  logic [BUF_W-1:0] w_in_placed;
  logic [BUF_W-1:0] w_buf_next;
  logic [CW-1:0]    w_full_next;

  // Room check uses registered fullness only, so in_ready never depends on consume.
  assign w_in_ready = ~flush & (({1'b0, r_full} + (CW+1)'(IN_W)) <= (CW+1)'(BUF_W));
  assign w_accept   = in_valid & w_in_ready;

  assign w_tot_mod = r_total[CW-1:0] & CW'(ALIGN - 1);
  assign w_align_d = (CW'(ALIGN) - w_tot_mod) & CW'(ALIGN - 1);

  always_comb begin
    w_ret   = '0;
    w_cause = ERR_NONE;
    if (!flush) begin
      if (align_en) begin
        if (w_align_d <= r_full) w_ret = w_align_d;
        else                     w_cause = ERR_ALIGN;
        if (consume_en) w_cause = ERR_CONFLICT;
      end else if (consume_en) begin
        if ((consume_bits <= r_full) && (consume_bits <= CW'(WIN_W))) w_ret = consume_bits;
        else                                                         w_cause = ERR_UNDERFLOW;
      end
    end
  end

  assign w_set_err = (w_cause != ERR_NONE);

  // New word lands directly below the bits that survive this cycle's retire.
  assign w_place_sh = CW'(BUF_W - IN_W) - (r_full - w_ret);

  ssm_barrel_shl #(.W(BUF_W), .SW(CW)) u_shl_retire (
    .i_data  (r_buf),
    .i_shamt (w_ret),
    .o_data  (w_buf_shl)
  );

  ssm_barrel_shl #(.W(BUF_W), .SW(CW)) u_shl_place (
    .i_data  ({{(BUF_W-IN_W){1'b0}}, in_data}),
    .i_shamt (w_place_sh),
    .o_data  (w_in_placed)
  );

  assign w_buf_next  = w_buf_shl | (w_accept ? w_in_placed : '0);
  assign w_full_next = r_full - w_ret + (w_accept ? CW'(IN_W) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_full  <= '0;
      r_total <= '0;
    end else if (flush) begin
      r_buf   <= '0;
      r_full  <= '0;
      r_total <= '0;
    end else begin
      r_buf   <= w_buf_next;
      r_full  <= w_full_next;
      r_total <= r_total + 32'(w_ret);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_set_err | (r_err & ~err_clr);
  end

  assign in_ready       = w_in_ready;
  assign win_data       = r_buf[BUF_W-1 -: WIN_W];
  assign win_valid      = (r_full >= CW'(WIN_W)) | (eos & (r_full != '0));
  assign fullness       = r_full;
  assign total_consumed = r_total;
  assign err            = r_err;

endmodule

// File: tb/tb_ssm_funnel_shifter_p.sv
// Directed self-checking bench for ssm_funnel_shifter_p with hand-computed expectations.
module tb_ssm_funnel_shifter_p;

  localparam int IN_W  = 128;
  localparam int WIN_W = 128;
  localparam int BUF_W = 256;
  localparam int ALIGN = 8;
  localparam int CW    = 9;

  localparam logic [127:0] W0 = {16{8'hA5}};
  localparam logic [127:0] W1 = {16{8'h3C}};
  localparam logic [127:0] W2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [383:0] STREAM = {W0, W1, W2};

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             eos;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic [CW-1:0]    fullness;
  logic             consume_en;
  logic [CW-1:0]    consume_bits;
  logic             align_en;
  logic             flush;
  logic [31:0]      total_consumed;
  logic             err;
  logic             err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssm_funnel_shifter_p #(
    .IN_W(IN_W), .WIN_W(WIN_W), .BUF_W(BUF_W), .ALIGN(ALIGN), .CW(CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .eos            (eos),
    .win_data       (win_data),
    .win_valid      (win_valid),
    .fullness       (fullness),
    .consume_en     (consume_en),
    .consume_bits   (consume_bits),
    .align_en       (align_en),
    .flush          (flush),
    .total_consumed (total_consumed),
    .err            (err),
    .err_clr        (err_clr)
  );

  // Window after c bits of STREAM have been retired with f bits held.
  function automatic logic [127:0] ewin(input int c, input int f);
    logic [383:0] s;
    logic [127:0] w;
    logic [127:0] m;
    s = STREAM << c;
    w = s[383:256];
    m = '1;
    if (f < 128) m = ~(m >> f);
    return w & m;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; eos = 1'b0; consume_en = 1'b0;
    consume_bits = '0; align_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_full", fullness, 0);
    chk("rst_total", total_consumed, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);

    rst = 1'b0; in_valid = 1'b1; in_data = W0;
    tick();
    chk("load1_full", fullness, 128);
    chk("load1_win", win_data, W0);
    chk("load1_in_ready", in_ready, 1);
    in_data = W1;
    tick();
    chk("load2_full", fullness, 256);
    chk("load2_in_ready", in_ready, 0);
    chk("load2_win_valid", win_valid, 1);
    chk("load2_win", win_data, W0);

    in_data = W2; consume_en = 1'b1; consume_bits = 9'd7;
    tick();
    chk("c7_full", fullness, 249);
    chk("c7_win", win_data, ewin(7, 249));
    chk("c7_in_ready", in_ready, 0);
    consume_bits = 9'd121;
    tick();
    chk("c121_full", fullness, 128);
    chk("c121_win", win_data, W1);
    chk("c121_in_ready", in_ready, 1);
    consume_bits = 9'd64;
    tick();
    chk("c64_full", fullness, 192);
    chk("c64_total", total_consumed, 192);
    chk("c64_win", win_data, ewin(192, 192));
    chk("c64_in_ready", in_ready, 0);

    in_valid = 1'b0; consume_bits = 9'd128;
    tick();
    chk("c128_full", fullness, 64);
    chk("c128_win_zero_fill", win_data, ewin(320, 64));
    chk("c128_win_valid", win_valid, 0);
    consume_bits = 9'd24;
    tick();
    chk("c24_full", fullness, 40);
    chk("c24_total", total_consumed, 344);
    consume_bits = 9'd41;
    tick();
    chk("under_full", fullness, 40);
    chk("under_total", total_consumed, 344);
    chk("under_err", err, 1);
    chk("under_win", win_data, ewin(344, 40));
    consume_en = 1'b0; err_clr = 1'b1;
    tick();
    chk("errclr", err, 0);
    consume_en = 1'b1; consume_bits = 9'd41;
    tick();
    chk("set_beats_clr", err, 1);
    consume_en = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("errclr2", err, 0);

    flush = 1'b1; in_valid = 1'b1; in_data = W0;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_full", fullness, 0);
    chk("flush_total", total_consumed, 0);
    chk("flush_win", win_data, 0);
    flush = 1'b0;
    tick();
    in_valid = 1'b0; consume_en = 1'b1; consume_bits = 9'd13;
    tick();
    chk("pre_align_total", total_consumed, 13);
    chk("pre_align_full", fullness, 115);
    consume_en = 1'b0; align_en = 1'b1;
    tick();
    chk("align_total", total_consumed, 16);
    chk("align_full", fullness, 112);
    chk("align_win", win_data, {{14{8'hA5}}, 16'h0000});
    tick();
    chk("align_noop_total", total_consumed, 16);
    chk("align_noop_err", err, 0);
    align_en = 1'b0; consume_en = 1'b1; consume_bits = 9'd5;
    tick();
    chk("c5_total", total_consumed, 21);
    align_en = 1'b1; consume_bits = 9'd4;
    tick();
    chk("conflict_total", total_consumed, 24);
    chk("conflict_full", fullness, 104);
    chk("conflict_err", err, 1);
    align_en = 1'b0; consume_en = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    consume_en = 1'b1; consume_bits = 9'd54;
    tick();
    chk("c54_full", fullness, 50);
    chk("noeos_win_valid", win_valid, 0);
    consume_en = 1'b0; eos = 1'b1;
    #1;
    chk("eos_win_valid", win_valid, 1);
    consume_en = 1'b1; consume_bits = 9'd50;
    tick();
    chk("drain_full", fullness, 0);
    chk("drain_win_valid", win_valid, 0);
    chk("drain_total", total_consumed, 128);
    eos = 1'b0; consume_en = 1'b0;

    in_valid = 1'b1; in_data = W0;
    tick();
    in_data = W1;
    tick();
    in_valid = 1'b0; consume_en = 1'b1; consume_bits = 9'd129;
    tick();
    chk("winw_over_full", fullness, 256);
    chk("winw_over_err", err, 1);
    consume_bits = 9'd128;
    tick();
    chk("winw_exact_full", fullness, 128);
    chk("winw_exact_win", win_data, W1);

    consume_bits = 9'd8; in_valid = 1'b1; in_data = W2;
    #1 rst = 1'b1;
    #1;
    chk("arst_full", fullness, 0);
    chk("arst_total", total_consumed, 0);
    chk("arst_err", err, 0);
    chk("arst_win", win_data, 0);
    chk("arst_in_ready", in_ready, 1);
    tick();
    chk("arst_no_accept", fullness, 0);
    rst = 1'b0; consume_en = 1'b0; in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
